// File: rtl/audio_cmd_queue.sv
// audio_cmd_queue
// Command FIFO and pacer that sits in front of the AC97 controller's
// cs/rw/data write port. CPU writes are buffered in a small FIFO. They are
// replayed as single-cycle write strobes, with a forced idle gap after each
// strobe so that a new cs never aborts a command that is still running.
// A status read returns {overflow, full, empty, 8'd0, count[4:0]}.
//
// Optional feature: define AUDIO_CMDQ_COALESCE_EN to drop a pushed word when
// it equals the most recently accepted word that is still queued.
//
// Handshake: the CPU side has no backpressure. A write (cpu_cs && !cpu_rw)
// is taken in the cycle it is presented. It is accepted when count < depth;
// otherwise it is dropped and the overflow flag is set. The controller side
// is a fire-and-forget strobe: aud_cs is high for exactly one cycle, with
// aud_rw low and aud_data stable.
module audio_cmd_queue #(
  parameter int DEPTH_LOG2 = 3,
  parameter int GAP_CYCLES = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cs,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_data,
  output logic [15:0] cpu_rdata,
  output logic        aud_cs,
  output logic        aud_rw,
  output logic [15:0] aud_data
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [15:0]         GAP_LOAD  = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t                state;
  logic [15:0]           gap_cnt;
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  overflow;

  logic push_req;
  logic read_req;
  logic full;
  logic empty;
  logic dup;
  logic push_ok;
  logic pop;

  assign push_req = cpu_cs && !cpu_rw;
  assign read_req = cpu_cs && cpu_rw;
  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);

`ifdef AUDIO_CMDQ_COALESCE_EN
  logic [15:0] last_word;
  logic        last_valid;

  // A push that repeats the still-queued last accepted word is silently merged.
  assign dup = last_valid && !empty && (cpu_data == last_word);

  // Tracks the last accepted word; it is forgotten once the FIFO drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_word  <= 16'd0;
      last_valid <= 1'b0;
    end else if (push_ok) begin
      last_word  <= cpu_data;
      last_valid <= 1'b1;
    end else if (count_next == '0) begin
      last_valid <= 1'b0;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Fullness is judged on the count at the start of the cycle, so a pop in
  // the same cycle never makes room for a push into a full FIFO.
  assign push_ok = push_req && !full && !dup;

  // The head leaves the FIFO when the pacer is free: from IDLE, or on the
  // last cycle of the gap.
  assign pop = !empty &&
               ((state == S_IDLE) || ((state == S_GAP) && (gap_cnt == 16'd0)));

  assign cpu_rdata = {overflow, full, empty, 8'd0, 5'(count)};

  // Next occupancy; a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage array; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= cpu_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      if (push_req && full && !dup) begin
        overflow <= 1'b1;
      end else if (read_req) begin
        overflow <= 1'b0;
      end
    end
  end

  // Pacer FSM. The strobe outputs are registered from the state, so aud_cs
  // is high during the cycle after ISSUE. The popped word is loaded into
  // aud_data one cycle ahead of the strobe and then held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      gap_cnt  <= 16'd0;
      aud_cs   <= 1'b0;
      aud_rw   <= 1'b1;
      aud_data <= 16'd0;
    end else begin
      aud_cs <= (state == S_ISSUE);
      aud_rw <= (state != S_ISSUE);
      if (pop) begin
        aud_data <= mem[rd_ptr];
      end
      case (state)
        S_IDLE: begin
          if (pop) state <= S_ISSUE;
        end
        S_ISSUE: begin
          gap_cnt <= GAP_LOAD;
          state   <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == 16'd0) begin
            state <= pop ? S_ISSUE : S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_cmd_queue.sv
// tb_audio_cmd_queue
// Randomized and directed stimulus for audio_cmd_queue. A reference model
// tracks the queue contents and the earliest edge at which the next strobe
// may start. All expected outputs come from that model. Define
// AUDIO_CMDQ_COALESCE_EN for both the bench and the RTL to exercise the
// coalescing build.
module tb_audio_cmd_queue;

  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;
  localparam int GAP   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_cs = 1'b0;
  logic        cpu_rw = 1'b0;
  logic [15:0] cpu_data = 16'd0;
  logic [15:0] cpu_rdata;
  logic        aud_cs;
  logic        aud_rw;
  logic [15:0] aud_data;

  audio_cmd_queue #(
    .DEPTH_LOG2 (DL),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_cs    (cpu_cs),
    .cpu_rw    (cpu_rw),
    .cpu_data  (cpu_data),
    .cpu_rdata (cpu_rdata),
    .aud_cs    (aud_cs),
    .aud_rw    (aud_rw),
    .aud_data  (aud_data)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  // Scoreboard state
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic        m_ov;
  logic [15:0] m_last;
  int          edge_n   = 0;
  int          next_ok;
  logic        m_cs;
  logic        m_pend;
  logic [15:0] m_data;
  int          rises    = 0;
  logic        prev_cs  = 1'b0;

`ifdef AUDIO_CMDQ_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ov    = 1'b0;
    m_last  = 16'd0;
    next_ok = edge_n;
    m_cs    = 1'b0;
    m_pend  = 1'b0;
    m_data  = 16'd0;
  endtask

  // Called right after each rising edge, while the inputs still hold the
  // values sampled on that edge.
  task automatic model_edge();
    int sz;
    bit do_pop;
    bit accept;
    if (!rst) begin
      model_reset();
      return;
    end
    edge_n++;
    sz     = exp_q.size();
    do_pop = (sz != 0) && (edge_n >= next_ok);
    accept = 1'b0;
    if (cpu_cs && !cpu_rw) begin
      if (COAL && sz != 0 && cpu_data == m_last) begin
        accept = 1'b0;
      end else if (sz == DEPTH) begin
        m_ov = 1'b1;
      end else begin
        accept = 1'b1;
      end
    end else if (cpu_cs && cpu_rw) begin
      m_ov = 1'b0;
    end
    m_cs   = m_pend;
    m_pend = 1'b0;
    if (do_pop) begin
      m_data  = exp_q.pop_front();
      m_pend  = 1'b1;
      next_ok = edge_n + GAP + 1;
    end
    if (accept) begin
      exp_q.push_back(cpu_data);
      m_last = cpu_data;
    end
  endtask

  task automatic check_outputs();
    int          sz;
    logic [15:0] st;
    sz = exp_q.size();
    check("aud_cs", {15'd0, aud_cs}, {15'd0, m_cs});
    check("aud_rw", {15'd0, aud_rw}, {15'd0, ~m_cs});
    check("aud_data", aud_data, m_data);
    if (cpu_cs && cpu_rw) begin
      st = {m_ov, (sz == DEPTH), (sz == 0), 8'd0, 5'(sz)};
      check("status", cpu_rdata, st);
    end
    if (aud_cs === 1'b1 && prev_cs == 1'b0) rises++;
    prev_cs = aud_cs;
  endtask

  // Driver: present one bus cycle, check mid-cycle, advance the model.
  task automatic cycle(input logic cs, input logic rw, input logic [15:0] data);
    cpu_cs   = cs;
    cpu_rw   = rw;
    cpu_data = data;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    model_reset();
    // Reset state
    rst = 1'b0;
    cycle(1'b1, 1'b1, 16'd0);
    check("rst_status", cpu_rdata, 16'h2000);
    cycle(1'b0, 1'b0, 16'd0);
    rst = 1'b1;
    idle(2);

    // Single command and status afterwards
    cycle(1'b0, 1'b0, 16'h1A2B);
    cycle(1'b1, 1'b0, 16'h1A2B);
    idle(10);
    cycle(1'b1, 1'b1, 16'd0);
    check("single_status", cpu_rdata, 16'h2000);

    // Pacing: three back-to-back pushes
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0A00 + 16'(i));
    idle(20);

    // Overflow: a burst longer than the FIFO can absorb
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 16'h0100 + 16'(i));
    cycle(1'b1, 1'b1, 16'd0);
    cycle(1'b1, 1'b1, 16'd0);
    idle(80);

    // Wrap-around: paced pushes keep a few entries resident
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 16'h2000 + 16'(i));
      idle($urandom_range(3, 6));
      if ((i % 5) == 0) cycle(1'b1, 1'b1, 16'd0);
    end
    idle(60);

    // Coalesce: 5, 5, 6 from an idle, empty queue
    rises = 0;
    cycle(1'b1, 1'b0, 16'h0005);
    cycle(1'b1, 1'b0, 16'h0005);
    cycle(1'b1, 1'b0, 16'h0006);
    idle(30);
    check("coalesce_strobes", 16'(rises), COAL ? 16'd2 : 16'd3);

    // Random traffic with narrow data to provoke duplicates and overflow
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)       cycle(1'b1, 1'b0, 16'($urandom_range(0, 3)));
      else if (r == 4) cycle(1'b1, 1'b1, 16'd0);
      else             cycle(1'b0, 1'b0, 16'd0);
    end

    // Asynchronous reset in the middle of a strobe
    cycle(1'b1, 1'b0, 16'hBEEF);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (aud_cs === 1'b1) begin
          seen = 1'b1;
          break;
        end
        cycle(1'b0, 1'b0, 16'd0);
      end
      check("rst_wait_strobe", {15'd0, seen}, 16'd1);
    end
    #2;
    cpu_cs = 1'b1;
    cpu_rw = 1'b1;
    rst    = 1'b0;
    #1;
    model_reset();
    check("async_rst_cs", {15'd0, aud_cs}, 16'd0);
    check("async_rst_rw", {15'd0, aud_rw}, 16'd1);
    check("async_rst_data", aud_data, 16'd0);
    check("async_rst_status", cpu_rdata, 16'h2000);
    @(posedge clk);
    model_edge();
    #1;
    cycle(1'b1, 1'b1, 16'd0);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 16'h7777);
    idle(12);
    cycle(1'b1, 1'b1, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_cmd_queue.md
# audio_cmd_queue

- Command FIFO and pacer directly upstream of the AC97 audio controller's `cs/rw/data` write port.
- Buffers 16-bit audio commands written by the CPU bus and replays them as single-cycle write strobes.
- Enforces a minimum gap between strobes. A new `cs` resets the controller's command engine, so a strobe arriving too early would abort the command still in flight.
- Exposes a status word so software can poll the fill level and the overflow flag.

## Interface
Parameters:
- `DEPTH_LOG2`, default 3: FIFO depth = 2^DEPTH_LOG2 entries; legal range 2..4.
- `GAP_CYCLES`, default 2500: idle `clk` cycles forced after each strobe. 2500 covers more than two AC97 frames at 50 MHz. Legal range 1..65535.

Ports:
- `clk` in 1: system clock, same domain as the controller's `clk`.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_cs` in 1: bus select.
- `cpu_rw` in 1: 1 = read status, 0 = write command.
- `cpu_data` in 16: command word to enqueue.
- `cpu_rdata` out 16: status word `{overflow, full, empty, 8'd0, count[4:0]}` (count zero-extended); combinational.
- `aud_cs` out 1: write strobe to the controller; registered.
- `aud_rw` out 1: held 0 while `aud_cs` is 1, otherwise 1; registered.
- `aud_data` out 16: command presented with `aud_cs`; registered; holds its last value between strobes.

## Operation
- **Push.** `cpu_cs && !cpu_rw`: the word is written at the tail if `count < depth`.
  - If the FIFO is full, the word is dropped and sticky `overflow` is set.
  - Fullness is judged on `count` at the start of the cycle. A pop in the same cycle does not admit a push to a full FIFO.
- **Status read.** `cpu_cs && cpu_rw`: `cpu_rdata` reflects the current state. `overflow` clears at the end of the read cycle; a read coinciding with a new overflow leaves it set.
- **Pointers and count.** Wrap modulo depth. `count` is DEPTH_LOG2+1 bits. Simultaneous push and pop leave `count` unchanged.
- **FSM, 3 states.**
  - IDLE: `aud_cs=0`. If `count != 0`, go to ISSUE; the head is popped into `aud_data` on that edge.
  - ISSUE (exactly 1 cycle): `aud_cs=1`, `aud_rw=0`. Load `gap_cnt = GAP_CYCLES-1`, then go to GAP.
  - GAP: `aud_cs=0`, `gap_cnt` decrements. When `gap_cnt == 0`:
    - if `count != 0`, pop the head and go to ISSUE;
    - otherwise go to IDLE.
- **Gap counter.** 16 bits. It is never loaded while already in GAP.
- **Reset (async, mid-operation included).** Any strobe is aborted immediately and all entries are discarded. Reset values:
  - `aud_cs=0`, `aud_rw=1`, `aud_data=0`
  - `count=0`, `empty=1`, `full=0`, `overflow=0`
  - pointers = 0, state = IDLE, `gap_cnt=0`

## Timing
- Push into an empty FIFO while in IDLE, sampled at edge N: `aud_cs` is high from edge N+2 to edge N+3. Latency is 2 cycles.
- Back-to-back queued commands produce `aud_cs` rising edges exactly GAP_CYCLES+1 cycles apart.
- A push landing during the last GAP cycle is not visible to the `count != 0` check until the next cycle. In that case the FSM goes to IDLE and issues one cycle later.
- `cpu_rdata` is valid in the same cycle as `cpu_cs`. `count`, `full` and `empty` update one edge after a push or pop.

## Configuration
- `AUDIO_CMDQ_COALESCE_EN` defined:
  - A push whose word equals the most recently accepted word that is still in the FIFO (`count != 0`) is discarded.
  - `count` is unchanged and `overflow` is not set.
  - The comparison is against a last-accepted register whose valid bit clears when `count` reaches 0.
- Undefined: every push is treated independently and duplicates are queued.

## Test plan
- **Reset:** assert `rst=0` mid-strobe. `aud_cs` drops asynchronously, `cpu_rdata = 16'h2000`, `aud_rw=1`, `aud_data=0`.
- **Single command:** push 16'h1A2B into an empty FIFO at edge N. One-cycle `aud_cs` at N+2 with `aud_data=16'h1A2B`, `aud_rw=0`. Status returns to 16'h2000.
- **Pacing:** `GAP_CYCLES=4`, push 3 words back-to-back. `aud_cs` rises at N+2, N+7, N+12, with data in push order.
- **Overflow:** depth 8; push 9 words while the FSM is held in a long gap. 9th word dropped, read status = 16'hC008, next read = 16'h4008 (or lower if pops have occurred meanwhile).
- **Wrap-around:** 20 pushes paced to keep 1–3 entries resident. All 20 strobes are issued in order with no loss.
- **Coalesce:** push 16'h0005 twice, then 16'h0006.
  - With `AUDIO_CMDQ_COALESCE_EN` defined: 2 strobes.
  - Without it: 3 strobes.
